snn_timestep_scheduler: RTL and testbench

Sequencer that runs one SNN inference of `sim_time` timesteps inside `snn_core_top`, sitting between the AXI config registers and the network datapath. Per timestep it:
- fetches the input spike batches from spike-pattern memory,
- steps the hidden layer and waits for it to finish,
- folds the layer's output spikes into the spike-counter memory by read-modify-write.

It owns `busy`, which locks host memory access while a run is in progress.

---
 rtl/snn_pkg.sv | 47 ++++
 rtl/snn_timestep_scheduler_if.sv | 33 +++
 rtl/snn_spike_count_updater.sv | 67 ++++++
 rtl/snn_timestep_scheduler.sv | 160 ++++++++++++++++
 tb/tb_snn_timestep_scheduler.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/snn_pkg.sv
// rtl/snn_pkg.sv - shared constants, scheduler state type and saturating increment
// Contents: network dimensions, register offsets, memory-select codes,
// CTRL_REG bit positions, sched_state_t, sat_inc().
package snn_pkg;

    localparam int NUM_INPUTS                     = 784;
    localparam int SPIKES_PER_BATCH               = 32;
    localparam int NUM_INPUT_SPIKE_BATCHES        = 25;
    localparam int SPIKE_PATTERN_BATCH_ADDR_WIDTH = 6;
    localparam int MAX_TIMESTEPS_BITS             = 7;
    localparam int NUM_OUTPUTS                    = 100;
    localparam int OUTPUT_SPIKE_ADDR_BITS         = 7;
    localparam int COUNT_WIDTH                    = 16;

    localparam logic [15:0] CTRL_REG       = 16'h0000;
    localparam logic [15:0] SIM_TIME_REG   = 16'h0004;
    localparam logic [15:0] MEM_CFG_REG    = 16'h0008;
    localparam logic [15:0] DEBUG_REG      = 16'h000C;
    localparam logic [15:0] EXT_MEM_OFFSET = 16'h0100;

    localparam logic [1:0] MEM_SEL_SYNAPSE = 2'd1;
    localparam logic [1:0] MEM_SEL_PATTERN = 2'd2;
    localparam logic [1:0] MEM_SEL_COUNTER = 2'd3;

    localparam int CTRL_START_BIT = 0;
    localparam int CTRL_ABORT_BIT = 1;

    localparam logic [OUTPUT_SPIKE_ADDR_BITS-1:0] LAST_OUTPUT =
        OUTPUT_SPIKE_ADDR_BITS'(NUM_OUTPUTS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FETCH,
        S_STEP,
        S_WAIT_LAYER,
        S_UPDATE,
        S_NEXT,
        S_DONE
    } sched_state_t;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/snn_timestep_scheduler_if.sv
// rtl/snn_timestep_scheduler_if.sv - pattern-memory, layer and counter-memory bus
// master: scheduler side (drives read strobes, in_spikes, layer_step, counter writes)
// slave:  memory/layer side (drives pat_rd_data, layer_done, out_spikes, cnt_rd_data)
interface snn_timestep_scheduler_if;
    import snn_pkg::*;

    logic                                      pat_rd_en;
    logic [SPIKE_PATTERN_BATCH_ADDR_WIDTH-1:0] pat_rd_batch;
    logic [MAX_TIMESTEPS_BITS-1:0]             pat_rd_timestep;
    logic [SPIKES_PER_BATCH-1:0]               pat_rd_data;
    logic [NUM_INPUTS-1:0]                     in_spikes;
    logic                                      layer_step;
    logic                                      layer_done;
    logic [NUM_OUTPUTS-1:0]                    out_spikes;
    logic [OUTPUT_SPIKE_ADDR_BITS-1:0]         cnt_addr;
    logic                                      cnt_rd_en;
    logic [COUNT_WIDTH-1:0]                    cnt_rd_data;
    logic                                      cnt_wr_en;
    logic [COUNT_WIDTH-1:0]                    cnt_wr_data;

    modport master (
        output pat_rd_en, pat_rd_batch, pat_rd_timestep, in_spikes, layer_step,
               cnt_addr, cnt_rd_en, cnt_wr_en, cnt_wr_data,
        input  pat_rd_data, layer_done, out_spikes, cnt_rd_data
    );

    modport slave (
        input  pat_rd_en, pat_rd_batch, pat_rd_timestep, in_spikes, layer_step,
               cnt_addr, cnt_rd_en, cnt_wr_en, cnt_wr_data,
        output pat_rd_data, layer_done, out_spikes, cnt_rd_data
    );

endinterface

// File: rtl/snn_spike_count_updater.sv
// rtl/snn_spike_count_updater.sv - read-modify-write scan of spike counters
// In:  clk, rst_n, i_clear (abort), i_go (start scan), i_spikes (latched),
//      i_cnt_rd_data (valid one cycle after o_cnt_rd_en)
// Out: o_cnt_addr/o_cnt_rd_en/o_cnt_wr_en/o_cnt_wr_data, o_finished (last scan cycle)
module snn_spike_count_updater
    import snn_pkg::*;
(
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              i_clear,
    input  logic                              i_go,
    input  logic [NUM_OUTPUTS-1:0]            i_spikes,
    input  logic [COUNT_WIDTH-1:0]            i_cnt_rd_data,
    output logic [OUTPUT_SPIKE_ADDR_BITS-1:0] o_cnt_addr,
    output logic                              o_cnt_rd_en,
    output logic                              o_cnt_wr_en,
    output logic [COUNT_WIDTH-1:0]            o_cnt_wr_data,
    output logic                              o_finished
);

    logic                              r_active;
    logic                              r_write;
    logic [OUTPUT_SPIKE_ADDR_BITS-1:0] r_idx;
    logic                              w_fire;
    logic                              w_neuron_done;

    // A firing neuron takes two cycles: read strobe, then write of the
    // incremented value while the address is held.
    always_comb begin
        w_fire        = i_spikes[r_idx];
        o_cnt_addr    = r_active ? r_idx : '0;
        o_cnt_rd_en   = r_active && !r_write && w_fire;
        o_cnt_wr_en   = r_active && r_write;
        o_cnt_wr_data = o_cnt_wr_en ? sat_inc(i_cnt_rd_data) : '0;
        w_neuron_done = r_active && (r_write || !w_fire);
        o_finished    = w_neuron_done && (r_idx == LAST_OUTPUT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active <= 1'b0;
            r_write  <= 1'b0;
            r_idx    <= '0;
        end else if (i_clear) begin
            r_active <= 1'b0;
            r_write  <= 1'b0;
            r_idx    <= '0;
        end else if (i_go) begin
            r_active <= 1'b1;
            r_write  <= 1'b0;
            r_idx    <= '0;
        end else if (r_active) begin
            if (o_cnt_rd_en) begin
                r_write <= 1'b1;
            end else begin
                r_write <= 1'b0;
                if (r_idx == LAST_OUTPUT) begin
                    r_active <= 1'b0;
                    r_idx    <= '0;
                end else begin
                    r_idx <= r_idx + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/snn_timestep_scheduler.sv
// rtl/snn_timestep_scheduler.sv - runs sim_time timesteps of one SNN inference
// In:  S_AXI_ACLK, S_AXI_ARESETN, start/abort pulses, sim_time, i_host_mem_req
// Out: busy, done pulse, timestep, o_host_mem_grant (host memory access while idle)
// bus: pattern-memory reads, in_spikes/layer_step/layer_done, counter-memory RMW
module snn_timestep_scheduler
    import snn_pkg::*;
(
    input  logic                          S_AXI_ACLK,
    input  logic                          S_AXI_ARESETN,
    input  logic                          start,
    input  logic                          abort,
    input  logic [MAX_TIMESTEPS_BITS-1:0] sim_time,
    output logic                          busy,
    output logic                          done,
    output logic [MAX_TIMESTEPS_BITS-1:0] timestep,
    input  logic                          i_host_mem_req,
    output logic                          o_host_mem_grant,
    snn_timestep_scheduler_if.master      bus
);

    sched_state_t                      r_state, w_next;
    logic [MAX_TIMESTEPS_BITS-1:0]     r_t_end, r_timestep;
    logic [OUTPUT_SPIKE_ADDR_BITS-1:0] r_idx;
    logic                              r_busy, r_host_grant, r_rd_pend;
    logic [SPIKE_PATTERN_BATCH_ADDR_WIDTH-1:0] r_rd_batch;
    logic [NUM_OUTPUTS-1:0]            r_out_spikes;
    logic [NUM_INPUTS-1:0]             w_in_spikes;

    logic w_start, w_kill, w_capture, w_upd_go, w_pat_rd_en, w_layer_step, w_done;
    logic [OUTPUT_SPIKE_ADDR_BITS-1:0] w_upd_addr, w_cnt_addr;
    logic w_upd_rd_en, w_upd_wr_en, w_upd_finished, w_cnt_rd_en, w_cnt_wr_en;
    logic [COUNT_WIDTH-1:0] w_upd_wr_data, w_cnt_wr_data;

    assign w_start   = (r_state == S_IDLE) && start && !abort;
    assign w_kill    = (r_state != S_IDLE) && abort;
    assign w_upd_go  = (r_state == S_WAIT_LAYER) && bus.layer_done;
    // Read data lags the strobe by one cycle; the final word lands in the
    // extra FETCH cycle after the last strobe.
    assign w_capture = (r_state == S_FETCH) && r_rd_pend;

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) r_state <= S_IDLE;
        else                r_state <= w_next;
    end

    always_comb begin
        w_next        = r_state;
        w_pat_rd_en   = 1'b0;
        w_layer_step  = 1'b0;
        w_done        = 1'b0;
        w_cnt_addr    = w_upd_addr;
        w_cnt_rd_en   = w_upd_rd_en;
        w_cnt_wr_en   = w_upd_wr_en;
        w_cnt_wr_data = w_upd_wr_data;
        case (r_state)
            S_IDLE:       if (w_start) w_next = S_CLEAR;
            S_CLEAR: begin
                w_cnt_addr    = r_idx;
                w_cnt_wr_en   = 1'b1;
                w_cnt_wr_data = '0;
                if (r_idx == LAST_OUTPUT) w_next = (r_t_end == '0) ? S_DONE : S_FETCH;
            end
            S_FETCH: begin
                w_pat_rd_en = (r_idx < OUTPUT_SPIKE_ADDR_BITS'(NUM_INPUT_SPIKE_BATCHES));
                if (r_idx == OUTPUT_SPIKE_ADDR_BITS'(NUM_INPUT_SPIKE_BATCHES)) w_next = S_STEP;
            end
            S_STEP: begin
                w_layer_step = 1'b1;
                w_next       = S_WAIT_LAYER;
            end
            S_WAIT_LAYER: if (bus.layer_done) w_next = S_UPDATE;
            S_UPDATE:     if (w_upd_finished) w_next = S_NEXT;
            S_NEXT:       w_next = (r_timestep + 1'b1 == r_t_end) ? S_DONE : S_FETCH;
            S_DONE: begin
                w_done = 1'b1;
                w_next = S_IDLE;
            end
            default:      w_next = S_IDLE;
        endcase
        if (w_kill) w_next = S_IDLE;
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_t_end      <= '0;
            r_timestep   <= '0;
            r_idx        <= '0;
            r_busy       <= 1'b0;
            r_host_grant <= 1'b0;
            r_rd_pend    <= 1'b0;
            r_rd_batch   <= '0;
            r_out_spikes <= '0;
        end else begin
            r_rd_pend    <= w_pat_rd_en;
            r_rd_batch   <= r_idx[SPIKE_PATTERN_BATCH_ADDR_WIDTH-1:0];
            r_host_grant <= i_host_mem_req && !r_busy && !w_start;
            if (w_kill) begin
                r_busy <= 1'b0;
                r_idx  <= '0;
            end else begin
                case (r_state)
                    S_IDLE: if (w_start) begin
                        r_busy     <= 1'b1;
                        r_t_end    <= sim_time;
                        r_timestep <= '0;
                        r_idx      <= '0;
                    end
                    S_CLEAR: r_idx <= (r_idx == LAST_OUTPUT) ? '0 : r_idx + 1'b1;
                    S_FETCH: r_idx <= (r_idx == OUTPUT_SPIKE_ADDR_BITS'(NUM_INPUT_SPIKE_BATCHES))
                                      ? '0 : r_idx + 1'b1;
                    S_WAIT_LAYER: if (bus.layer_done) r_out_spikes <= bus.out_spikes;
                    S_NEXT:  r_timestep <= r_timestep + 1'b1;
                    S_DONE:  r_busy <= 1'b0;
                    default: ;
                endcase
            end
        end
    end

    // One register per batch word; the last word keeps only the bits below NUM_INPUTS.
    for (genvar g = 0; g < NUM_INPUT_SPIKE_BATCHES; g++) begin : g_batch
        localparam int LO = g * SPIKES_PER_BATCH;
        localparam int W  = (NUM_INPUTS - LO < SPIKES_PER_BATCH) ? NUM_INPUTS - LO : SPIKES_PER_BATCH;
        logic [W-1:0] r_word;
        always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
            if (!S_AXI_ARESETN)                                                     r_word <= '0;
            else if (w_capture && r_rd_batch == SPIKE_PATTERN_BATCH_ADDR_WIDTH'(g)) r_word <= bus.pat_rd_data[W-1:0];
        end
        assign w_in_spikes[LO +: W] = r_word;
    end

    snn_spike_count_updater u_updater (
        .clk           (S_AXI_ACLK),
        .rst_n         (S_AXI_ARESETN),
        .i_clear       (w_kill),
        .i_go          (w_upd_go),
        .i_spikes      (r_out_spikes),
        .i_cnt_rd_data (bus.cnt_rd_data),
        .o_cnt_addr    (w_upd_addr),
        .o_cnt_rd_en   (w_upd_rd_en),
        .o_cnt_wr_en   (w_upd_wr_en),
        .o_cnt_wr_data (w_upd_wr_data),
        .o_finished    (w_upd_finished)
    );

    assign busy                = r_busy;
    assign done                = w_done;
    assign timestep            = r_timestep;
    assign o_host_mem_grant    = r_host_grant;
    assign bus.pat_rd_en       = w_pat_rd_en;
    assign bus.pat_rd_batch    = w_pat_rd_en ? r_idx[SPIKE_PATTERN_BATCH_ADDR_WIDTH-1:0] : '0;
    assign bus.pat_rd_timestep = r_timestep;
    assign bus.in_spikes       = w_in_spikes;
    assign bus.layer_step      = w_layer_step;
    assign bus.cnt_addr        = w_cnt_addr;
    assign bus.cnt_rd_en       = w_cnt_rd_en;
    assign bus.cnt_wr_en       = w_cnt_wr_en;
    assign bus.cnt_wr_data     = w_cnt_wr_data;

endmodule

// File: tb/tb_snn_timestep_scheduler.sv
// tb/tb_snn_timestep_scheduler.sv - directed self-checking bench for snn_timestep_scheduler
module tb_snn_timestep_scheduler;
    import snn_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [6:0] sim_time = '0;
    logic       busy, done, host_grant;
    logic       host_req = 1'b1;
    logic [6:0] timestep;

    snn_timestep_scheduler_if bus();

    snn_timestep_scheduler dut (
        .S_AXI_ACLK       (clk),
        .S_AXI_ARESETN    (rst_n),
        .start            (start),
        .abort            (abort),
        .sim_time         (sim_time),
        .busy             (busy),
        .done             (done),
        .timestep         (timestep),
        .i_host_mem_req   (host_req),
        .o_host_mem_grant (host_grant),
        .bus              (bus)
    );

    always #5 clk = ~clk;

    // Memory and layer models
    logic [15:0] cnt_mem [0:127];
    logic [3:0]  sr = '0;
    logic        spur = 1'b0;
    logic        poke_req = 1'b0;
    logic [99:0] out_mask = '0;

    always @(posedge clk) begin
        if (bus.pat_rd_en) bus.pat_rd_data <= 32'(bus.pat_rd_batch);
        if (bus.cnt_wr_en) cnt_mem[bus.cnt_addr] <= bus.cnt_wr_data;
        else if (poke_req) cnt_mem[7] <= 16'hFFFE;
        if (bus.cnt_rd_en) bus.cnt_rd_data <= cnt_mem[bus.cnt_addr];
        sr <= {sr[2:0], bus.layer_step};
    end
    assign bus.layer_done = sr[3] | spur;
    assign bus.out_spikes = out_mask;

    // Event monitors
    int m_wr = 0, m_wr_nz = 0, m_both = 0, m_pat = 0, m_step = 0, m_done = 0;
    int b_wr, b_wr_nz, b_both, b_pat, b_step, b_done;
    logic [6:0] m_last_ts = '0;
    always @(negedge clk) if (rst_n) begin
        if (bus.cnt_wr_en) m_wr++;
        if (bus.cnt_wr_en && bus.cnt_wr_data != 0) m_wr_nz++;
        if (bus.cnt_wr_en && bus.cnt_rd_en) m_both++;
        if (bus.pat_rd_en) begin m_pat++; m_last_ts = bus.pat_rd_timestep; end
        if (bus.layer_step) m_step++;
        if (done) m_done++;
    end

    int n_checks = 0, n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic mark();
        b_wr = m_wr; b_wr_nz = m_wr_nz; b_both = m_both;
        b_pat = m_pat; b_step = m_step; b_done = m_done;
    endtask

    task automatic run(input logic [6:0] st, input bit poke, input bit noise, output int cyc);
        bit did;
        did = 0;
        sim_time = st;
        start = 1'b1;
        @(posedge clk);
        mark();
        cyc = 1;
        @(negedge clk);
        start = 1'b0;
        while (!done && cyc < 4000) begin
            if (!did && bus.pat_rd_en && (poke || noise)) begin
                did = 1;
                poke_req = poke;
                if (noise) begin start = 1'b1; sim_time = 7'd9; spur = 1'b1; end
            end
            @(posedge clk);
            cyc++;
            @(negedge clk);
            poke_req = 1'b0; start = 1'b0; spur = 1'b0; sim_time = st;
        end
        check("done_seen", done, 1);
        check("busy_at_done", busy, 1);
        check("grant_while_busy", host_grant, 0);
        @(posedge clk);
        @(negedge clk);
        check("busy_after_done", busy, 0);
    endtask

    int cyc, nz;
    bit found;

    initial begin
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_timestep", timestep, 0);
        check("rst_pat_rd_en", bus.pat_rd_en, 0);
        check("rst_cnt_wr_en", bus.cnt_wr_en, 0);
        check("rst_layer_step", bus.layer_step, 0);
        check("rst_in_spikes", bus.in_spikes[63:0], 0);
        check("rst_grant", host_grant, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: zero timesteps -> clear only
        out_mask = '0;
        run(7'd0, 0, 0, cyc);
        check("t1_latency", cyc + 1, 102);
        check("t1_clear_writes", m_wr - b_wr, 100);
        check("t1_clear_nonzero", m_wr_nz - b_wr_nz, 0);
        check("t1_pat_reads", m_pat - b_pat, 0);
        check("t1_layer_steps", m_step - b_step, 0);
        check("t1_done_count", m_done - b_done, 1);

        // 2: three timesteps, neuron 5 fires each step
        out_mask = 100'(1) << 5;
        run(7'd3, 0, 0, cyc);
        check("t2_latency", cyc + 1, 501);
        check("t2_cnt5", cnt_mem[5], 3);
        nz = 0;
        for (int i = 0; i < 100; i++) if (i != 5 && cnt_mem[i] !== 16'd0) nz++;
        check("t2_other_cnts", nz, 0);
        check("t2_in_batch0", bus.in_spikes[31:0], 0);
        check("t2_in_batch1", bus.in_spikes[63:32], 1);
        check("t2_in_batch23", bus.in_spikes[767:736], 23);
        check("t2_in_batch24", bus.in_spikes[783:768], 24);
        check("t2_done_count", m_done - b_done, 1);
        check("t2_pat_reads", m_pat - b_pat, 75);
        check("t2_layer_steps", m_step - b_step, 3);
        check("t2_rd_wr_overlap", m_both - b_both, 0);
        check("t2_timestep", timestep, 3);
        check("t2_last_pat_ts", m_last_ts, 2);
        @(negedge clk);
        check("t2_grant_idle", host_grant, 1);

        // 3: saturation of a preloaded counter
        out_mask = 100'(1) << 7;
        run(7'd4, 1, 0, cyc);
        check("t3_latency", cyc + 1, 634);
        check("t3_cnt7_sat", cnt_mem[7], 16'hFFFF);
        check("t3_rd_wr_overlap", m_both - b_both, 0);

        // 4: abort in WAIT_LAYER at timestep 2, then a clean run
        out_mask = 100'(1) << 5;
        sim_time = 7'd5;
        start = 1'b1;
        @(posedge clk);
        mark();
        @(negedge clk);
        start = 1'b0;
        found = 0;
        for (int i = 0; i < 2000 && !found; i++) begin
            if (bus.layer_step && timestep == 7'd2) found = 1;
            else @(negedge clk);
        end
        check("t4_reached_ts2", found, 1);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("t4_busy_after_abort", busy, 0);
        check("t4_cnt_wr_after_abort", bus.cnt_wr_en, 0);
        repeat (20) @(negedge clk);
        check("t4_no_done", m_done - b_done, 0);
        check("t4_still_idle", busy, 0);
        out_mask = 100'(1) << 9;
        run(7'd2, 0, 0, cyc);
        check("t4_rerun_latency", cyc + 1, 368);
        check("t4_rerun_cnt9", cnt_mem[9], 2);
        check("t4_rerun_cnt5", cnt_mem[5], 0);

        // 5: start while busy and spurious layer_done in FETCH are ignored
        out_mask = 100'(1) << 3;
        run(7'd2, 0, 1, cyc);
        check("t5_latency", cyc + 1, 368);
        check("t5_cnt3", cnt_mem[3], 2);
        check("t5_layer_steps", m_step - b_step, 2);
        check("t5_timestep", timestep, 2);
        check("t5_done_count", m_done - b_done, 1);

        // 6: asynchronous reset during UPDATE
        out_mask = 100'(1) << 3;
        sim_time = 7'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 0;
        for (int i = 0; i < 2000 && !found; i++) begin
            if (bus.cnt_rd_en && busy) found = 1;
            else @(negedge clk);
        end
        check("t6_reached_update", found, 1);
        check("t6_in_spikes_loaded", bus.in_spikes[63:32], 1);
        rst_n = 1'b0;
        #1;
        check("t6_busy", busy, 0);
        check("t6_cnt_rd_en", bus.cnt_rd_en, 0);
        check("t6_cnt_addr", bus.cnt_addr, 0);
        check("t6_in_spikes", bus.in_spikes[63:32], 0);
        check("t6_timestep", timestep, 0);
        check("t6_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("t6_idle_after_reset", busy, 0);
        check("t6_no_pat_rd", bus.pat_rd_en, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
